// File: rtl/stoch_bipolar_decoder.sv
// Stochastic-to-binary decoder: counts ones per channel over 2^L sampled cycles
// and emits 2*ones-2^L (or raw ones when STOCH_DEC_UNIPOLAR_EN is defined).
module stoch_bipolar_decoder #(
    parameter int unsigned N = 3,
    parameter int unsigned L = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [N-1:0]         in,
    input  logic                 ack,
    output logic                 busy,
    output logic                 valid,
    output logic [N*(L+2)-1:0]   out
);

    localparam int unsigned CW = L + 1;
    localparam int unsigned OW = L + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [N-1:0][CW-1:0]  ones;
    logic [N-1:0][CW-1:0]  ones_fin_c;
    logic [L-1:0]          win;
    logic [N*OW-1:0]       res_c;
    logic                  last_c;
    logic                  clr_c;
    logic                  smp_c;
    logic                  busy_d;
    logic                  valid_d;

    // Final sample of the window: counter at its top value with a live sample
    assign last_c = (state == ACCUM) && en && (win == {L{1'b1}});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last_c) state_nxt = DONE;
            DONE:    if (ack) state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and next-cycle output decode
    always_comb begin
        clr_c   = 1'b0;
        smp_c   = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        clr_c   = ((state == IDLE) && start) || ((state == DONE) && ack && start);
        smp_c   = (state == ACCUM) && en;
        busy_d  = (state_nxt == ACCUM);
        valid_d = (state_nxt == DONE);
    end

    // Result including the sample taken on the closing edge
    always_comb begin
        ones_fin_c = '0;
        res_c      = '0;
        for (int n = 0; n < N; n++) begin
            ones_fin_c[n] = ones[n] + CW'(in[n]);
`ifdef STOCH_DEC_UNIPOLAR_EN
            res_c[n*OW +: OW] = OW'(ones_fin_c[n]);
`else
            res_c[n*OW +: OW] = OW'({ones_fin_c[n], 1'b0}) - (OW'(1) << L);
`endif
        end
    end

    // Counters, result register and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones  <= '0;
            win   <= '0;
            out   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            busy  <= busy_d;
            valid <= valid_d;
            if (clr_c) begin
                ones <= '0;
                win  <= '0;
            end else if (smp_c) begin
                win <= win + L'(1);
                for (int n = 0; n < N; n++) begin
                    ones[n] <= ones_fin_c[n];
                end
            end
            if (last_c) begin
                out <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_stoch_bipolar_decoder.sv
// Bench for stoch_bipolar_decoder at N=3, L=4: table of stream patterns with
// constant expected ones counts, a result scoreboard and handshake corner cases.
module tb_stoch_bipolar_decoder;

    localparam int unsigned N  = 3;
    localparam int unsigned L  = 4;
    localparam int unsigned OW = L + 2;
    localparam int unsigned W  = 1 << L;

    typedef struct packed {
        logic [2:0][15:0] pat;
        logic [2:0][4:0]  ones;
    } vec_t;

    logic                clk;
    logic                rst;
    logic                en;
    logic                start;
    logic [N-1:0]        in;
    logic                ack;
    logic                busy;
    logic                valid;
    logic [N*OW-1:0]     out;

    int                  total;
    int                  bad;
    logic [N*OW-1:0]     sb[$];
    vec_t                vecs[5];
    logic [N*OW-1:0]     held;

    stoch_bipolar_decoder #(.N(N), .L(L)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .in    (in),
        .ack   (ack),
        .busy  (busy),
        .valid (valid),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*OW-1:0] exp_out(input logic [2:0][4:0] k);
        logic [N*OW-1:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
`ifdef STOCH_DEC_UNIPOLAR_EN
            r[c*OW +: OW] = OW'(k[c]);
`else
            r[c*OW +: OW] = OW'(2 * int'(k[c]) - 16);
`endif
        end
        return r;
    endfunction

    // Drive one full window of samples, optionally with a stall inserted
    task automatic feed(input vec_t v, input int stall_at, input int stall_len);
        for (int s = 0; s < int'(W); s++) begin
            if (s == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    en = 1'b0;
                    in = 3'b111;
                    check("busy_stall", 32'(busy), 32'd1);
                    tick();
                end
            end
            en = 1'b1;
            in = {v.pat[2][s], v.pat[1][s], v.pat[0][s]};
            check("busy_accum", 32'(busy), 32'd1);
            check("valid_accum", 32'(valid), 32'd0);
            tick();
        end
        in = '0;
    endtask

    // Result is due right after the last sample edge; a late one is a failure
    task automatic wait_result(input string name);
        int waited;
        logic [N*OW-1:0] e;
        waited = 0;
        while (!valid && waited < 4) begin
            tick();
            waited++;
        end
        check({name, "_latency"}, 32'(waited), 32'd0);
        check({name, "_valid"}, 32'(valid), 32'd1);
        check({name, "_busy_done"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_out"}, 32'(out), 32'(e));
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack_pulse(input string name);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({name, "_ack_valid"}, 32'(valid), 32'd0);
        check({name, "_ack_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        start = 1'b0;
        in    = '0;
        ack   = 1'b0;

        vecs[0] = '{pat: {16'h0000, 16'h0000, 16'hFFFF}, ones: {5'd0,  5'd0,  5'd16}};
        vecs[1] = '{pat: {16'h5555, 16'h5555, 16'h5555}, ones: {5'd8,  5'd8,  5'd8}};
        vecs[2] = '{pat: {16'h7777, 16'hFFF0, 16'h0FFF}, ones: {5'd12, 5'd12, 5'd12}};
        vecs[3] = '{pat: {16'hFFFE, 16'h00FF, 16'h0001}, ones: {5'd15, 5'd8,  5'd1}};
        vecs[4] = '{pat: {16'hFFFF, 16'hFFFF, 16'hFFFF}, ones: {5'd16, 5'd16, 5'd16}};

        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven windows with EN held high
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp_out(vecs[i].ones));
            start_pulse();
            feed(vecs[i], -1, 0);
            wait_result($sformatf("vec%0d", i));
            ack_pulse($sformatf("vec%0d", i));
        end

        // Stall of 5 cycles mid-window with IN high: stalled cycles are not counted
        sb.push_back(exp_out(vecs[0].ones));
        start_pulse();
        feed(vecs[0], 7, 5);
        wait_result("stall");

        // Backpressure: result held, START ignored while waiting for ACK
        held = out;
        for (int k = 0; k < 10; k++) begin
            start = k[0];
            tick();
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_busy", 32'(busy), 32'd0);
            check("bp_out", 32'(out), 32'(held));
        end
        start = 1'b0;
        ack_pulse("bp");
        tick();
        check("bp_idle_busy", 32'(busy), 32'd0);

        // Back-to-back: ACK and START together restart directly
        sb.push_back(exp_out(vecs[3].ones));
        start_pulse();
        feed(vecs[3], -1, 0);
        wait_result("b2b_first");
        held = out;
        sb.push_back(exp_out(vecs[2].ones));
        ack   = 1'b1;
        start = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_valid", 32'(valid), 32'd0);
        check("b2b_out_hold", 32'(out), 32'(held));
        feed(vecs[2], -1, 0);
        wait_result("b2b_second");
        ack_pulse("b2b");

        // Asynchronous reset partway through a window
        start_pulse();
        for (int s = 0; s < 9; s++) begin
            en = 1'b1;
            in = 3'b111;
            tick();
        end
        check("pre_rst_out", 32'(out != '0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_out", 32'(out), 32'd0);
        #2;
        rst = 1'b0;
        in  = '0;
        tick();
        sb.push_back(exp_out(vecs[3].ones));
        start_pulse();
        feed(vecs[3], -1, 0);
        wait_result("post_rst");
        ack_pulse("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
